// File: rtl/apb_fsm_controller_if.sv
// Bus bundle between the AHB slave-interface stage, the APB master FSM
// and the APB peripherals. "master" is the view seen by the bridge FSM.
interface apb_fsm_controller_if;
  // Decoded AHB side, produced by the upstream slave-interface stage
  logic        valid;
  logic [2:0]  TEMP_SEL;
  logic [1:0]  HTRANS;
  logic        HREADYin;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HADDR_1;
  logic [31:0] HWDATA;
  // APB side
  logic        PREADY;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  // Back-pressure and status towards AHB
  logic        HREADYout;
  logic        apb_timeout;

  modport master (
    input  valid, TEMP_SEL, HTRANS, HREADYin, HWRITE, HADDR, HADDR_1, HWDATA, PREADY,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYout, apb_timeout
  );

  modport slave (
    output valid, TEMP_SEL, HTRANS, HREADYin, HWRITE, HADDR, HADDR_1, HWDATA, PREADY,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYout, apb_timeout
  );
endinterface

// File: rtl/apb_fsm_controller.sv
// APB master state machine of the AHB-to-APB bridge. Turns accepted AHB
// transfers into APB setup/access cycles, stalls AHB through HREADYout
// while a transfer is in flight and aborts transfers stuck in wait states.
module apb_fsm_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  apb_fsm_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WWAIT,
    RSETUP,
    WSETUP,
    RENABLE,
    WENABLE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] wait_cnt;

  logic sel_onehot;
  logic acc;
  logic at_limit;
  logic in_enable;
  logic decode_slot;

  // Only a single-peripheral select counts as a real transfer
  assign sel_onehot  = (bus.TEMP_SEL == 3'b001) || (bus.TEMP_SEL == 3'b010) ||
                       (bus.TEMP_SEL == 3'b100);
  assign acc         = bus.valid & bus.HTRANS[1] & bus.HREADYin & sel_onehot;
  assign at_limit    = (wait_cnt == CNT_LIMIT);
  assign in_enable   = (state == RENABLE) || (state == WENABLE);
  // Cycles in which a new AHB transfer may be picked up: idle, or the
  // completing access cycle so pipelined transfers run back to back
  assign decode_slot = (state == IDLE) || (in_enable && bus.PREADY);

  // AHB ready: free when idle, otherwise only on the last access cycle
  always_comb begin
    bus.HREADYout = 1'b0;
    case (state)
      IDLE:             bus.HREADYout = 1'b1;
      RENABLE, WENABLE: bus.HREADYout = bus.PREADY | at_limit;
      default:          bus.HREADYout = 1'b0;
    endcase
  end

  // Transfer sequencing with registered APB outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state           <= IDLE;
      sel_q           <= 3'b000;
      wait_cnt        <= '0;
      bus.PSEL        <= 3'b000;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= 32'h0;
      bus.PWDATA      <= 32'h0;
      bus.apb_timeout <= 1'b0;
    end else begin
      bus.apb_timeout <= 1'b0;
      if (decode_slot) begin
        bus.PENABLE <= 1'b0;
        if (acc && !bus.HWRITE) begin
          state      <= RSETUP;
          bus.PADDR  <= bus.HADDR;
          bus.PSEL   <= bus.TEMP_SEL;
          bus.PWRITE <= 1'b0;
        end else if (acc && bus.HWRITE) begin
          // Write data arrives one cycle later, so park in WWAIT first
          state    <= WWAIT;
          sel_q    <= bus.TEMP_SEL;
          bus.PSEL <= 3'b000;
        end else begin
          state    <= IDLE;
          bus.PSEL <= 3'b000;
        end
      end else begin
        case (state)
          WWAIT: begin
            state      <= WSETUP;
            bus.PADDR  <= bus.HADDR_1;
            bus.PWDATA <= bus.HWDATA;
            bus.PSEL   <= sel_q;
            bus.PWRITE <= 1'b1;
          end
          RSETUP: begin
            state       <= RENABLE;
            bus.PENABLE <= 1'b1;
            wait_cnt    <= '0;
          end
          WSETUP: begin
            state       <= WENABLE;
            bus.PENABLE <= 1'b1;
            wait_cnt    <= '0;
          end
          RENABLE, WENABLE: begin
            // Only reached with PREADY low: count a wait state or give up
            if (at_limit) begin
              state           <= IDLE;
              bus.PSEL        <= 3'b000;
              bus.PENABLE     <= 1'b0;
              bus.apb_timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          default: begin
            state       <= IDLE;
            bus.PSEL    <= 3'b000;
            bus.PENABLE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Self-checking bench for apb_fsm_controller: directed scenarios followed
// by random traffic, all checked cycle by cycle against a transfer-timeline
// reference model.
module tb_apb_fsm_controller;
  localparam int TIMEOUT = 16;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b1;

  apb_fsm_controller_if bus ();

  apb_fsm_controller #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: the transfer in flight and the cycle its APB setup
  // phase appears on the bus; everything else follows from elapsed cycles.
  bit          have;
  logic [31:0] x_addr, x_data;
  logic [2:0]  x_sel;
  bit          x_wr;
  int          x_setup;
  logic [31:0] last_addr, last_data;
  int          pulse_cyc;
  int          pready_low_left;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit tb_acc();
    return bus.valid && bus.HTRANS[1] && bus.HREADYin && ($countones(bus.TEMP_SEL) == 1);
  endfunction

  task automatic model_reset();
    have      = 1'b0;
    last_addr = 32'h0;
    last_data = 32'h0;
    pulse_cyc = -100;
  endtask

  task automatic try_accept();
    if (tb_acc()) begin
      have    = 1'b1;
      x_addr  = bus.HADDR;
      x_sel   = bus.TEMP_SEL;
      x_wr    = bus.HWRITE;
      x_data  = 32'h0;
      x_setup = cyc + (bus.HWRITE ? 2 : 1);
    end
  endtask

  // Compare this cycle's outputs, then advance the model across the edge
  task automatic check_and_step();
    logic [2:0] e_psel;
    bit e_pen, e_rdy;
    int k;
    k = 0;
    if (!have) begin
      e_psel = 3'b000; e_pen = 1'b0; e_rdy = 1'b1;
    end else if (cyc < x_setup) begin
      e_psel = 3'b000; e_pen = 1'b0; e_rdy = 1'b0;
    end else if (cyc == x_setup) begin
      last_addr = x_addr;
      if (x_wr) last_data = x_data;
      e_psel = x_sel; e_pen = 1'b0; e_rdy = 1'b0;
    end else begin
      k = cyc - x_setup - 1;
      e_psel = x_sel; e_pen = 1'b1;
      e_rdy = bus.PREADY || (k == TIMEOUT - 1);
    end
    check("PSEL", bus.PSEL, e_psel);
    check("PENABLE", bus.PENABLE, e_pen);
    check("HREADYout", bus.HREADYout, e_rdy);
    check("apb_timeout", bus.apb_timeout, (cyc == pulse_cyc));
    check("PADDR", bus.PADDR, last_addr);
    check("PWDATA", bus.PWDATA, last_data);
    if (e_psel != 3'b000) check("PWRITE", bus.PWRITE, x_wr);

    if (!have) begin
      try_accept();
    end else if (cyc < x_setup) begin
      if (cyc == x_setup - 1) x_data = bus.HWDATA;
    end else if (cyc > x_setup) begin
      if (bus.PREADY) begin
        $display("done  %s addr=%08h data=%08h sel=%03b waits=%0d", x_wr ? "WR" : "RD",
                 x_addr, x_wr ? x_data : 32'h0, x_sel, k);
        have = 1'b0;
        try_accept();
      end else if (k == TIMEOUT - 1) begin
        $display("abort %s addr=%08h sel=%03b after %0d access cycles", x_wr ? "WR" : "RD",
                 x_addr, x_sel, TIMEOUT);
        have      = 1'b0;
        pulse_cyc = cyc + 1;
      end
    end
  endtask

  // Drive one cycle of inputs (called just after a rising edge)
  task automatic apply(input bit v, input logic [2:0] sel, input logic [1:0] ht, input bit hw,
                       input logic [31:0] addr, input logic [31:0] wd, input bit pr);
    bus.HADDR_1  = bus.HADDR;
    bus.valid    = v;
    bus.TEMP_SEL = sel;
    bus.HTRANS   = ht;
    bus.HREADYin = 1'b1;
    bus.HWRITE   = hw;
    bus.HADDR    = addr;
    bus.HWDATA   = wd;
    bus.PREADY   = pr;
    @(negedge HCLK);
    check_and_step();
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  task automatic idle(input bit pr);
    apply(1'b0, 3'b000, 2'b00, 1'b0, 32'h0, 32'h0, pr);
  endtask

  task automatic random_cycle();
    logic [2:0] sels [10];
    sels = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b011, 3'b111, 3'b110};
    bus.HADDR_1  = bus.HADDR;
    bus.valid    = ($urandom_range(0, 9) < 8);
    bus.TEMP_SEL = sels[$urandom_range(0, 9)];
    bus.HTRANS   = 2'($urandom_range(0, 3));
    bus.HREADYin = ($urandom_range(0, 9) < 9);
    bus.HWRITE   = 1'($urandom_range(0, 1));
    bus.HADDR    = $urandom;
    bus.HWDATA   = $urandom;
    if (pready_low_left > 0) begin
      bus.PREADY = 1'b0;
      pready_low_left--;
    end else if ($urandom_range(0, 39) == 0) begin
      bus.PREADY = 1'b0;
      pready_low_left = $urandom_range(14, 22);
    end else begin
      bus.PREADY = ($urandom_range(0, 3) != 0);
    end
    @(negedge HCLK);
    check_and_step();
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  initial begin
    bus.valid = 1'b0; bus.TEMP_SEL = 3'b000; bus.HTRANS = 2'b00; bus.HREADYin = 1'b1;
    bus.HWRITE = 1'b0; bus.HADDR = 32'h0; bus.HADDR_1 = 32'h0; bus.HWDATA = 32'h0;
    bus.PREADY = 1'b1;
    pready_low_left = 0;
    model_reset();

    // Power-on reset values
    #2 HRESETn = 1'b0;
    #1;
    check("rst_PSEL", bus.PSEL, 3'b000);
    check("rst_PENABLE", bus.PENABLE, 1'b0);
    check("rst_PWRITE", bus.PWRITE, 1'b0);
    check("rst_PADDR", bus.PADDR, 32'h0);
    check("rst_PWDATA", bus.PWDATA, 32'h0);
    check("rst_HREADYout", bus.HREADYout, 1'b1);
    check("rst_apb_timeout", bus.apb_timeout, 1'b0);
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1;

    idle(1'b1); idle(1'b1);

    // Single read with zero wait states
    apply(1'b1, 3'b010, 2'b10, 1'b0, 32'h4000_1004, 32'h0, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Single write
    apply(1'b1, 3'b100, 2'b10, 1'b1, 32'h4000_2008, 32'h0, 1'b1);
    apply(1'b0, 3'b000, 2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Read followed by a write presented during the completing access cycle
    apply(1'b1, 3'b001, 2'b10, 1'b0, 32'h4000_0000, 32'h0, 1'b1);
    idle(1'b1);
    apply(1'b1, 3'b010, 2'b10, 1'b1, 32'h4000_0010, 32'h0, 1'b1);
    apply(1'b0, 3'b000, 2'b00, 1'b0, 32'h0, 32'h1234_5678, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Read with three wait states
    apply(1'b1, 3'b100, 2'b11, 1'b0, 32'h4000_0044, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b0); idle(1'b0); idle(1'b0);
    idle(1'b1); idle(1'b1);

    // Timeout with a transfer held on the bus throughout; it is taken only after the abort
    apply(1'b1, 3'b001, 2'b10, 1'b0, 32'h4000_0080, 32'h0, 1'b1);
    for (int i = 0; i < TIMEOUT + 2; i++)
      apply(1'b1, 3'b010, 2'b10, 1'b0, 32'h4000_00C0, 32'h0, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Valid decode but no peripheral selected
    apply(1'b1, 3'b000, 2'b10, 1'b0, 32'h4000_0100, 32'h0, 1'b1);
    apply(1'b1, 3'b011, 2'b10, 1'b1, 32'h4000_0104, 32'h0, 1'b1);
    idle(1'b1); idle(1'b1);

    // Asynchronous reset while a write sits in its access phase
    apply(1'b1, 3'b100, 2'b10, 1'b1, 32'h4000_3000, 32'h0, 1'b1);
    apply(1'b0, 3'b000, 2'b00, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
    idle(1'b0);
    HRESETn = 1'b0;
    #1;
    check("arst_PSEL", bus.PSEL, 3'b000);
    check("arst_PENABLE", bus.PENABLE, 1'b0);
    check("arst_HREADYout", bus.HREADYout, 1'b1);
    check("arst_PADDR", bus.PADDR, 32'h0);
    model_reset();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    cyc++;
    idle(1'b1); idle(1'b1);

    // Random traffic
    for (int i = 0; i < 2000; i++) random_cycle();
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
- APB-side master state machine of the AHB-to-APB bridge. Sits directly downstream of the AHB slave interface stage.
- Consumes that stage's decoded outputs: valid, TEMP_SEL, pipelined HADDR/HWDATA and HWRITEreg.
- Drives the APB bus: PSEL, PENABLE, PADDR, PWDATA, PWRITE.
- Stalls the AHB master via HREADYout while an APB transfer is in flight, and aborts transfers that exceed a wait-state timeout.

Parameters:
- TIMEOUT, 16, maximum ACCESS-phase cycles with PREADY low before the transfer is aborted (valid range 2..255).
- CNT_W, 8, width of the wait-state counter.

Ports:
- HCLK  in  1  AHB clock; all registers update on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- valid  in  1  upstream address-range decode of current HADDR.
- TEMP_SEL  in  3  upstream one-hot peripheral select for current HADDR.
- HTRANS  in  2  AHB transfer type; bit1=1 means NONSEQ/SEQ.
- HREADYin  in  1  AHB bus ready.
- HWRITE  in  1  current address-phase direction.
- HADDR  in  32  current address-phase address.
- HADDR_1  in  32  address registered one cycle earlier by upstream.
- HWDATA  in  32  AHB write data, data phase.
- PREADY  in  1  APB slave ready.
- PSEL  out  3  one-hot APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- HREADYout  out  1  bridge ready to AHB.
- apb_timeout  out  1  one-cycle pulse when a transfer is aborted.

Behaviour:
- Reset (asynchronous, any state, mid-transfer included):
  - state=IDLE.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, counter=0, apb_timeout=0.
  - HREADYout=1.
- Accept condition: acc = valid & HTRANS[1] & HREADYin & (TEMP_SEL is one of 001/010/100).
  - Transfers with TEMP_SEL=000 or non-one-hot are ignored; treated as IDLE/BUSY.
- States: IDLE, WWAIT, RSETUP, WSETUP, RENABLE, WENABLE.
- IDLE:
  - acc & ~HWRITE -> RSETUP. Register PADDR=HADDR, PSEL=TEMP_SEL, PWRITE=0.
  - acc & HWRITE -> WWAIT. Register sel_q=TEMP_SEL.
  - Otherwise stay in IDLE.
- WWAIT:
  - Unconditionally -> WSETUP.
  - Register PADDR=HADDR_1, PWDATA=HWDATA, PSEL=sel_q, PWRITE=1.
- RSETUP/WSETUP:
  - PENABLE=0.
  - -> RENABLE/WENABLE, registering PENABLE=1 and counter=0.
- RENABLE/WENABLE:
  - PREADY=1 completes the transfer. Apply the IDLE decode in the same cycle, so a pipelined next transfer goes directly to RSETUP/WSETUP/WWAIT.
  - When that decode selects no new transfer -> IDLE with PSEL=0, PENABLE=0.
  - PREADY=0 with counter<TIMEOUT-1: counter+1; PADDR, PWDATA, PSEL, PWRITE and PENABLE held stable.
  - PREADY=0 with counter==TIMEOUT-1: abort -> IDLE, PSEL=0, PENABLE=0, apb_timeout=1 for exactly the next cycle. A pipelined transfer is not accepted on the abort cycle.
- HREADYout is combinational:
  - 1 in IDLE.
  - 1 in ENABLE states when PREADY=1 or on the abort cycle.
  - 0 in WWAIT, RSETUP, WSETUP, and ENABLE states while waiting.
- Read data returns on HRDATA=PRDATA upstream. The master samples it on the same edge where HREADYout=1 in RENABLE.
- Latency with zero-wait APB:
  - Read: address phase plus 2 cycles (RSETUP, RENABLE).
  - Write: address phase plus 3 cycles (WWAIT, WSETUP, WENABLE).
- The counter saturates; no wrap. PADDR and PWDATA retain their last values in IDLE.

Test Plan:
- Reset mid-WENABLE (HRESETn low for 1 cycle) -> PSEL=0, PENABLE=0, HREADYout=1 immediately (asynchronous); state=IDLE after release.
- Single read, HADDR=0x4000_1004, TEMP_SEL=010, PREADY=1 -> PSEL=010, PADDR=0x4000_1004, PWRITE=0 the next cycle; PENABLE=1 the following cycle with HREADYout=1; IDLE after.
- Single write, HADDR=0x4000_2008, HWDATA=0xDEAD_BEEF -> HREADYout=0 in WWAIT; PADDR=0x4000_2008, PWDATA=0xDEAD_BEEF, PSEL=100, PWRITE=1; PENABLE 1 cycle later; completion 3 cycles after the address phase.
- Back-to-back read at 0x4000_0000 then write at 0x4000_0010, the second address presented during RENABLE with PREADY=1 -> goes directly to WWAIT; no IDLE cycle, no lost transfer.
- Wait states, PREADY low for 3 cycles in RENABLE -> PENABLE held for 4 cycles, HREADYout=0 for 3, PADDR and PSEL stable throughout.
- Timeout, PREADY stuck low, TIMEOUT=16 -> abort after 16 ENABLE cycles: HREADYout=1 on the abort cycle, apb_timeout=1 for 1 cycle, then IDLE. TEMP_SEL=000 with valid=1 -> no PSEL asserted.
